puf_eval_controller: RTL and testbench
======================================

Name: puf_eval_controller

Overview:
Sequencer for the serial ring-oscillator PUF datapath. It accepts an 8-bit challenge and, one bit at a time, enables the selected RO pair. It then runs the pair's edge counters for a fixed window and compares the two counts to produce one response bit. After 8 bits it presents the assembled response and holds it until the host acknowledges. It sits between the board-level challenge/ack pins and the RO bank plus counter pair.

Parameters:
N_RO, 32, number of ring oscillators; fixed at 32 (4 per challenge bit, 8 bits).
CNT_W, 16, width of each RO edge counter.
SETTLE, 4, cycles the ROs run with counters held in clear before measurement (>=1).
WINDOW, 1024, measurement window in clk cycles (>=1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  request evaluation; sampled only in IDLE
challenge  in  8  challenge word; latched on accepted start
host_ack  in  1  host has read response; sampled only in DONE
cnt_a  in  CNT_W  edge count of RO selected by sel_a
cnt_b  in  CNT_W  edge count of RO selected by sel_b
ro_en  out  N_RO  one-hot-pair enables for the RO bank
sel_a  out  5  RO index routed to counter A
sel_b  out  5  RO index routed to counter B
cnt_clr  out  1  synchronous clear for both counters
cnt_run  out  1  counters increment while high
busy  out  1  high in any state other than IDLE
done  out  1  response valid; high only in DONE
response  out  8  assembled response, bit i from challenge bit i
ties  out  8  bit i set when cnt_a == cnt_b for bit i
bit_idx  out  3  challenge bit currently being evaluated

Behaviour:
- Reset (rst high at an edge): state=IDLE, bit_idx=0, ro_en=0, sel_a=sel_b=0, cnt_clr=1, cnt_run=0, busy=0, done=0, response=0, ties=0. Reset wins over every other input, in any state, including mid-measurement.
- States are IDLE, SETTLE, MEASURE, COMPARE and DONE.
- IDLE: cnt_clr=1 and ro_en=0.
  - start=1 at an edge latches challenge, clears response and ties, sets bit_idx=0 and moves to SETTLE.
- Pair mapping for bit i with latched challenge bit c:
  - sel_a = 4i + 2c.
  - sel_b = 4i + 2c + 1.
  - ro_en has exactly bits sel_a and sel_b set during SETTLE and MEASURE; ro_en=0 in all other states.
- SETTLE: lasts exactly SETTLE cycles, with cnt_clr=1 and cnt_run=0. It then moves to MEASURE.
- MEASURE: lasts exactly WINDOW cycles, with cnt_clr=0 and cnt_run=1. It then moves to COMPARE.
- COMPARE: lasts 1 cycle, with cnt_run=0 and cnt_clr=0; counter values are stable.
  - The comparison is unsigned, full CNT_W width.
  - response[bit_idx] = (cnt_a > cnt_b).
  - ties[bit_idx] = (cnt_a == cnt_b); on a tie the response bit is 0.
  - If bit_idx=7, go to DONE; otherwise increment bit_idx and go to SETTLE.
- DONE: done=1, response and ties are stable, and cnt_clr=1.
  - host_ack=1 at an edge moves to IDLE; done falls the following cycle.
  - response and ties keep their values in IDLE until the next accepted start.
- start while busy is ignored; it is not queued. host_ack outside DONE is ignored.
- Timing: start accepted at edge k gives done=1 from edge k + 8*(SETTLE+WINDOW+1) onward. With defaults that is 8232 cycles.
- Counter saturation is the counter's responsibility; the controller compares whatever values it is given.

Test Plan:
- Bench parameters SETTLE=2, WINDOW=8 throughout. Check reset: rst high 2 cycles -> all outputs at reset values. Check timing: start accepted at edge k -> done=1 at edge k+88 and not before; busy=1 from edge k+1.
- challenge=8'hA5, counter model returns cnt_a=100 and cnt_b=50 when sel_a is even-pair-low, else the swap -> response matches per-bit mapping. ro_en follows 0x3 then 0xC pattern shifted by 4i as c selects.
- Ties: cnt_a=cnt_b=77 for all bits -> response=8'h00, ties=8'hFF. Compare at full width: cnt_a=16'h8000 vs cnt_b=16'h7FFF -> response bit=1.
- start pulsed again mid-MEASURE with a different challenge -> ignored; result reflects the original challenge. host_ack held high before DONE -> ignored, and DONE exits on the first edge after entry.
- rst asserted during bit 3 MEASURE -> next cycle IDLE, ro_en=0, response=0. A fresh start then completes normally in 88 cycles.
- Back-to-back: host_ack then start on the next cycle -> second evaluation accepted. response holds the old value until that start edge, then clears.

Source files
------------

// File: rtl/puf_eval_controller.sv
// Sequencer for the serial ring-oscillator PUF: one challenge bit at a time it
// enables an RO pair, measures both for a fixed window and records which ran faster.
module puf_eval_controller #(
  parameter int N_RO   = 32,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 4,
  parameter int WINDOW = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       challenge,
  input  logic             host_ack,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic [CNT_W-1:0] cnt_b,
  output logic [N_RO-1:0]  ro_en,
  output logic [4:0]       sel_a,
  output logic [4:0]       sel_b,
  output logic             cnt_clr,
  output logic             cnt_run,
  output logic             busy,
  output logic             done,
  output logic [7:0]       response,
  output logic [7:0]       ties,
  output logic [2:0]       bit_idx
);

  localparam int TMAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_MEASURE, S_COMPARE, S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [TW-1:0]  tmr;
  logic [7:0]     chal;
  logic           last_settle, last_window;
  logic [4:0]     pair_base;

  assign last_settle = (tmr == TW'(SETTLE - 1));
  assign last_window = (tmr == TW'(WINDOW - 1));
  // {i, c, 0} == 4i + 2c: the pair index of bit i
  assign pair_base   = {bit_idx, chal[bit_idx], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tmr      <= '0;
      chal     <= '0;
      bit_idx  <= '0;
      response <= '0;
      ties     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          chal     <= challenge;
          response <= '0;
          ties     <= '0;
          bit_idx  <= '0;
          tmr      <= '0;
        end
        S_SETTLE:  tmr <= last_settle ? '0 : tmr + TW'(1);
        S_MEASURE: tmr <= last_window ? '0 : tmr + TW'(1);
        S_COMPARE: begin
          response[bit_idx] <= (cnt_a > cnt_b);
          ties[bit_idx]     <= (cnt_a == cnt_b);
          if (bit_idx != 3'd7) bit_idx <= bit_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    ro_en    = '0;
    sel_a    = '0;
    sel_b    = '0;
    cnt_clr  = 1'b1;
    cnt_run  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_SETTLE;
      end
      S_SETTLE: begin
        ro_en = N_RO'(2'b11) << pair_base;
        sel_a = pair_base;
        sel_b = pair_base | 5'd1;
        if (last_settle) state_nx = S_MEASURE;
      end
      S_MEASURE: begin
        ro_en   = N_RO'(2'b11) << pair_base;
        sel_a   = pair_base;
        sel_b   = pair_base | 5'd1;
        cnt_clr = 1'b0;
        cnt_run = 1'b1;
        if (last_window) state_nx = S_COMPARE;
      end
      S_COMPARE: begin
        // selects stay on the pair so the frozen counts remain routed
        sel_a    = pair_base;
        sel_b    = pair_base | 5'd1;
        cnt_clr  = 1'b0;
        state_nx = (bit_idx == 3'd7) ? S_DONE : S_SETTLE;
      end
      S_DONE: begin
        done = 1'b1;
        if (host_ack) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_puf_eval_controller.sv
// Randomized self-checking bench for puf_eval_controller with SETTLE=2, WINDOW=8;
// a per-RO count table stands in for the RO bank and counter pair.
module tb_puf_eval_controller;
  localparam int SET = 2;
  localparam int WIN = 8;
  localparam int PER = SET + WIN + 1;
  localparam int TOT = 8 * PER;

  logic        clk = 0;
  logic        rst, start, host_ack;
  logic [7:0]  challenge;
  logic [15:0] cnt_a, cnt_b;
  logic [31:0] ro_en;
  logic [4:0]  sel_a, sel_b;
  logic        cnt_clr, cnt_run, busy, done;
  logic [7:0]  response, ties;
  logic [2:0]  bit_idx;

  logic [15:0] fa [32];
  logic [15:0] fb [32];
  int checks = 0, failures = 0;

  puf_eval_controller #(.N_RO(32), .CNT_W(16), .SETTLE(SET), .WINDOW(WIN)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge), .host_ack(host_ack),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .ro_en(ro_en), .sel_a(sel_a), .sel_b(sel_b),
    .cnt_clr(cnt_clr), .cnt_run(cnt_run), .busy(busy), .done(done),
    .response(response), .ties(ties), .bit_idx(bit_idx));

  always #5 clk = ~clk;

  // counter model: each RO has a fixed count, routed by the selects
  assign cnt_a = fa[sel_a];
  assign cnt_b = fb[sel_b];

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic void model(input logic [7:0] ch, output logic [7:0] r, output logic [7:0] t);
    for (int i = 0; i < 8; i++) begin
      int ia, ib;
      ia = 4 * i + 2 * int'(ch[i]);
      ib = ia + 1;
      r[i] = fa[ia] > fb[ib];
      t[i] = fa[ia] == fb[ib];
    end
  endfunction

  task automatic rand_counts();
    for (int r = 0; r < 32; r++) begin
      fa[r] = 16'($urandom_range(0, 40));
      fb[r] = 16'($urandom_range(0, 40));
    end
  endtask

  task automatic check_reset_vals(input string nm);
    logic [65:0] act, exp;
    act = {ro_en, sel_a, sel_b, cnt_clr, cnt_run, busy, done, response, ties, bit_idx};
    exp = {32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives one evaluation; abort_at >= 0 asserts rst at that cycle offset instead of finishing.
  task automatic run_eval(input logic [7:0] ch, input bit mid_start, input bit early_ack,
                          input int abort_at);
    logic [7:0] er, et;
    model(ch, er, et);
    challenge = ch; start = 1; host_ack = early_ack;
    step();
    start = 0;
    checks++;
    if ({response, ties} !== 16'h0) begin
      failures++;
      $display("FAIL clear_on_start: got %h expected 0000", {response, ties});
    end
    for (int j = 0; j < TOT; j++) begin
      int b, p, c;
      logic [48:0] act, exp;
      logic [4:0] sa;
      b = j / PER; p = j % PER; c = int'(ch[b]);
      sa = 5'(4 * b + 2 * c);
      exp = {(p < SET + WIN) ? (32'h3 << sa) : 32'h0, sa, sa + 5'd1, 3'(b),
             (p >= SET && p < SET + WIN), (p < SET), 1'b1, 1'b0};
      act = {ro_en, sel_a, sel_b, bit_idx, cnt_run, cnt_clr, busy, done};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL seq j=%0d: got %h expected %h", j, act, exp);
      end
      if (j == abort_at) begin
        rst = 1; step(); rst = 0; host_ack = 0;
        check_reset_vals("reset_mid_measure");
        return;
      end
      if (mid_start && j == 20) begin start = 1; challenge = ~ch; end
      step();
      start = 0;
    end
    checks++;
    if ({done, busy, response, ties} !== {1'b1, 1'b1, er, et}) begin
      failures++;
      $display("FAIL done_result: got %h expected %h", {done, busy, response, ties},
               {1'b1, 1'b1, er, et});
    end
    if (!early_ack) begin
      step();
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL done_hold: got %b expected 1", done); end
      host_ack = 1;
    end
    step();
    host_ack = 0;
    checks++;
    if ({done, busy, response, ties} !== {1'b0, 1'b0, er, et}) begin
      failures++;
      $display("FAIL ack_exit: got %h expected %h", {done, busy, response, ties},
               {1'b0, 1'b0, er, et});
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; host_ack = 0; challenge = 0;
    step(); step();
    check_reset_vals("reset");
    rst = 0;
    step();
    check_reset_vals("idle_after_reset");
  endtask

  task automatic test_timing();
    rand_counts();
    run_eval(8'($urandom), 0, 0, -1);
  endtask

  task automatic test_mapping();
    for (int r = 0; r < 32; r++) begin
      fa[r] = (r % 4 == 0) ? 16'd100 : 16'd50;
      fb[r] = (r % 4 == 1) ? 16'd50 : 16'd100;
    end
    run_eval(8'hA5, 0, 0, -1);
    checks++;
    if (response !== 8'h5A) begin
      failures++;
      $display("FAIL mapping_a5: got %h expected 5a", response);
    end
  endtask

  task automatic test_ties();
    for (int r = 0; r < 32; r++) begin fa[r] = 16'd77; fb[r] = 16'd77; end
    run_eval(8'($urandom), 0, 0, -1);
    checks++;
    if ({response, ties} !== 16'h00FF) begin
      failures++;
      $display("FAIL ties: got %h expected 00ff", {response, ties});
    end
    for (int r = 0; r < 32; r++) begin fa[r] = 16'h8000; fb[r] = 16'h7FFF; end
    run_eval(8'($urandom), 0, 0, -1);
    checks++;
    if ({response, ties} !== 16'hFF00) begin
      failures++;
      $display("FAIL full_width: got %h expected ff00", {response, ties});
    end
  endtask

  task automatic test_ignored_inputs();
    rand_counts();
    run_eval(8'($urandom), 1, 1, -1);
  endtask

  task automatic test_reset_mid();
    rand_counts();
    run_eval(8'($urandom), 0, 0, 3 * PER + SET + 2);
    step();
    check_reset_vals("idle_after_abort");
    run_eval(8'($urandom), 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] er, et, ch;
    for (int n = 0; n < 2; n++) begin
      rand_counts();
      ch = 8'($urandom);
      model(ch, er, et);
      run_eval(ch, 0, 0, -1);
      checks++;
      if ({response, ties} !== {er, et}) begin
        failures++;
        $display("FAIL b2b_hold: got %h expected %h", {response, ties}, {er, et});
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_mapping();
    test_ties();
    test_ignored_inputs();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
